// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data RAM arbiter: port-select encoding
// and default geometry.
package mem_arbiter_pkg;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_sel_e;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_CNT_W  = 16;

  // One-hot grant vector for a port; bit position equals the port encoding.
  function automatic logic [1:0] port_onehot(input port_sel_e p);
    return (p == PORT_D) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin selector: on a tie the port that did not win
// most recently is granted.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  port_sel_e  last_gnt,
  output logic [1:0] gnt
);

  always_comb begin
    // NOTE: default every always_comb output first so no path infers a latch.
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = port_onehot(PORT_IF);
      2'b10:   gnt = port_onehot(PORT_D);
      2'b11:   gnt = (last_gnt == PORT_IF) ? port_onehot(PORT_D) : port_onehot(PORT_IF);
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between instruction fetch and data ports with
// round-robin arbitration, latency-1 reads and a saturating contention counter.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [CNT_W-1:0]  stall_cnt
);

  port_sel_e        last_gnt_q, last_gnt_d;
  logic             if_pend_q, if_pend_d;
  logic             d_pend_q, d_pend_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic [31:0]      d_rdata_q, d_rdata_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [1:0]       gnt;
  logic             stall_evt;

  // Byte-offset and out-of-range address bits are dropped silently.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                              d_addr[31:ADDR_W+2], d_addr[1:0]};

  rr_arb2 u_rr_arb2 (
    .req      ({d_req, if_req}),
    .last_gnt (last_gnt_q),
    .gnt      (gnt)
  );

  assign if_gnt = gnt[0];
  assign d_gnt  = gnt[1];

  // The granted access drives the RAM in the same cycle.
  assign mem_en    = if_gnt | d_gnt;
  assign mem_we    = d_gnt & d_we;
  assign mem_addr  = d_gnt ? d_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];
  assign mem_wdata = d_gnt ? d_wdata : 32'h0;

  assign stall_evt = (if_req & ~if_gnt) | (d_req & ~d_gnt);

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (d_gnt) begin
      last_gnt_d = PORT_D;
    end else if (if_gnt) begin
      last_gnt_d = PORT_IF;
    end

    if_pend_d = if_gnt;
    d_pend_d  = d_gnt & ~d_we;

    // Returned words are captured so rdata holds until the port's next rvalid.
    if_rdata_d = if_pend_q ? mem_rdata : if_rdata_q;
    d_rdata_d  = d_pend_q  ? mem_rdata : d_rdata_q;

    stall_d = stall_q;
    if (stall_evt && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_gnt_q <= PORT_IF;
      if_pend_q  <= 1'b0;
      d_pend_q   <= 1'b0;
      // NOTE: the rdata holding registers are plain flops, not RAM, so they are
      // reset to give a defined 0 on the outputs during reset.
      if_rdata_q <= 32'h0;
      d_rdata_q  <= 32'h0;
      stall_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      last_gnt_q <= last_gnt_d;
      if_pend_q  <= if_pend_d;
      d_pend_q   <= d_pend_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      stall_q    <= stall_d;
    end
  end

  assign if_rvalid = if_pend_q;
  assign d_rvalid  = d_pend_q;
  assign if_rdata  = if_pend_q ? mem_rdata : if_rdata_q;
  assign d_rdata   = d_pend_q  ? mem_rdata : d_rdata_q;
  assign stall_cnt = stall_q;

endmodule
